// File: rtl/irq_arbiter8.sv
// Eight-line level-request interrupt arbiter: edge-detected pending bits, sticky overflow flags,
// a writable enable mask and a valid/ready output that holds its selection until accepted.
module irq_arbiter8 #(
  parameter logic [7:0] MASK_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_wr,
  input  logic [7:0] mask_din,
  input  logic       ovf_clr,
  input  logic       irq_ready,
  output logic       irq_valid,
  output logic [7:0] irq_onehot,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic [7:0] mask,
  output logic [7:0] ovf
);

  typedef enum logic {StIdle, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] ovf_q, ovf_d;
  logic [7:0] onehot_q, onehot_d;
  logic [2:0] id_q, id_d;

  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] enabled;
  logic [7:0] top_onehot;
  logic [2:0] top_id;
  logic       accept;

  assign rise    = req & ~req_q;
  assign accept  = (state_q == StHold) & irq_ready;
  assign clr     = accept ? onehot_q : 8'h00;
  assign enabled = pending_q & mask_q;

  // Set beats clear; an overflow only counts when the bit is not being retired this edge.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    ovf_d     = (ovf_clr ? 8'h00 : ovf_q) | (rise & pending_q & ~clr);
    mask_d    = mask_wr ? mask_din : mask_q;
  end

  // Ascending scan so the highest enabled line is the one left standing.
  always_comb begin
    top_onehot = 8'h00;
    top_id     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (enabled[i]) begin
        top_onehot    = 8'h00;
        top_onehot[i] = 1'b1;
        top_id        = i[2:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    id_d     = id_q;
    unique case (state_q)
      StIdle: begin
        if (|enabled) begin
          state_d  = StHold;
          onehot_d = top_onehot;
          id_d     = top_id;
        end else begin
          onehot_d = 8'h00;
          id_d     = 3'd0;
        end
      end
      StHold: begin
        // Accept always drops to idle for one cycle before the next pick.
        if (irq_ready) begin
          state_d  = StIdle;
          onehot_d = 8'h00;
          id_d     = 3'd0;
        end
      end
    endcase
  end

  // req_q resets high so a line held through reset release is not seen as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      req_q     <= 8'hFF;
      pending_q <= 8'h00;
      mask_q    <= MASK_RESET;
      ovf_q     <= 8'h00;
      onehot_q  <= 8'h00;
      id_q      <= 3'd0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      onehot_q  <= onehot_d;
      id_q      <= id_d;
    end
  end

  assign irq_valid  = (state_q == StHold);
  assign irq_onehot = onehot_q;
  assign irq_id     = id_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign ovf        = ovf_q;

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(onehot_q));
  a_valid_onehot: assert property (@(posedge clk) disable iff (rst)
                                   irq_valid == (onehot_q != 8'h00));
  a_id_idle: assert property (@(posedge clk) disable iff (rst) !irq_valid |-> (id_q == 3'd0));

endmodule

// File: tb/tb_irq_arbiter8.sv
// Bench for irq_arbiter8: a per-line behavioural model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_irq_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic       ovf_clr;
  logic       irq_ready;
  logic       irq_valid;
  logic [7:0] irq_onehot;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] mask;
  logic [7:0] ovf;

  int checks = 0;
  int errors = 0;

  irq_arbiter8 #(.MASK_RESET(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask_wr   (mask_wr),
    .mask_din  (mask_din),
    .ovf_clr   (ovf_clr),
    .irq_ready (irq_ready),
    .irq_valid (irq_valid),
    .irq_onehot(irq_onehot),
    .irq_id    (irq_id),
    .pending   (pending),
    .mask      (mask),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: per-line flags and the index of the presented line (-1 = nothing presented).
  bit m_pend[8];
  bit m_mask[8];
  bit m_ovf[8];
  bit m_prev[8];
  int m_sel;

  function automatic logic [7:0] pack(input bit v[8]);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[b];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 8; b++) begin
        m_pend[b] = 1'b0;
        m_mask[b] = 1'b1;
        m_ovf[b]  = 1'b0;
        m_prev[b] = 1'b1;
      end
      m_sel = -1;
    end else begin
      int  nsel;
      bit  acc;
      bit  rising;
      bit  cleared;
      acc = (m_sel >= 0) && irq_ready;
      if (m_sel >= 0) begin
        nsel = irq_ready ? -1 : m_sel;
      end else begin
        nsel = -1;
        for (int b = 7; b >= 0; b--) begin
          if (m_pend[b] && m_mask[b]) begin
            nsel = b;
            break;
          end
        end
      end
      for (int b = 0; b < 8; b++) begin
        rising  = req[b] && !m_prev[b];
        cleared = acc && (m_sel == b);
        if (ovf_clr) m_ovf[b] = 1'b0;
        if (rising && m_pend[b] && !cleared) m_ovf[b] = 1'b1;
        if (rising) m_pend[b] = 1'b1;
        else if (cleared) m_pend[b] = 1'b0;
        if (mask_wr) m_mask[b] = mask_din[b];
        m_prev[b] = req[b];
      end
      m_sel = nsel;
    end
  end

  always @(negedge clk) begin
    chk("model_valid", {31'd0, irq_valid}, {31'd0, m_sel >= 0});
    chk("model_onehot", {24'd0, irq_onehot}, (m_sel >= 0) ? (32'd1 << m_sel) : 32'd0);
    chk("model_id", {29'd0, irq_id}, (m_sel >= 0) ? m_sel : 0);
    chk("model_pending", {24'd0, pending}, {24'd0, pack(m_pend)});
    chk("model_mask", {24'd0, mask}, {24'd0, pack(m_mask)});
    chk("model_ovf", {24'd0, ovf}, {24'd0, pack(m_ovf)});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [7:0] oh,
                         input logic [2:0] id);
    chk({name, "_valid"}, {31'd0, irq_valid}, {31'd0, v});
    chk({name, "_onehot"}, {24'd0, irq_onehot}, {24'd0, oh});
    chk({name, "_id"}, {29'd0, irq_id}, {29'd0, id});
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; mask_wr = 1'b0; mask_din = 8'h00; ovf_clr = 1'b0; irq_ready = 1'b0;
    cyc();
    cyc();
    chk_out("reset", 1'b0, 8'h00, 3'd0);
    chk("reset_pending", {24'd0, pending}, 32'h00);
    chk("reset_mask", {24'd0, mask}, 32'hFF);
    chk("reset_ovf", {24'd0, ovf}, 32'h00);
    rst = 1'b0;
    cyc();

    // Two lines rise together; highest first, bubble, then the other.
    req = 8'h24; cyc();
    chk("s1_pending", {24'd0, pending}, 32'h24);
    chk("s1_e0_valid", {31'd0, irq_valid}, 32'd0);
    req = 8'h00; cyc();
    chk_out("s1_first", 1'b1, 8'h20, 3'd5);
    irq_ready = 1'b1; cyc();
    chk_out("s1_bubble", 1'b0, 8'h00, 3'd0);
    chk("s1_pending_after", {24'd0, pending}, 32'h04);
    irq_ready = 1'b0; cyc();
    chk_out("s1_second", 1'b1, 8'h04, 3'd2);

    // Higher-priority arrival while holding does not preempt.
    req = 8'h80; cyc();
    chk_out("s2_hold", 1'b1, 8'h04, 3'd2);
    chk("s2_pending", {24'd0, pending}, 32'h84);
    req = 8'h00; cyc();
    chk_out("s2_hold2", 1'b1, 8'h04, 3'd2);
    irq_ready = 1'b1; cyc();
    chk_out("s2_bubble", 1'b0, 8'h00, 3'd0);
    irq_ready = 1'b0; cyc();
    chk_out("s2_next", 1'b1, 8'h80, 3'd7);
    irq_ready = 1'b1; cyc();
    irq_ready = 1'b0;

    // Masked line stays pending but is not presented until unmasked.
    mask_wr = 1'b1; mask_din = 8'h7F; cyc();
    chk("s3_mask", {24'd0, mask}, 32'h7F);
    mask_wr = 1'b0; req = 8'h80; cyc();
    chk("s3_pending", {24'd0, pending}, 32'h80);
    req = 8'h00; cyc();
    chk("s3_masked_valid", {31'd0, irq_valid}, 32'd0);
    mask_wr = 1'b1; mask_din = 8'hFF; cyc();
    chk("s3_unmask_valid", {31'd0, irq_valid}, 32'd0);
    mask_wr = 1'b0; cyc();
    chk_out("s3_present", 1'b1, 8'h80, 3'd7);
    irq_ready = 1'b1; cyc();
    irq_ready = 1'b0;

    // Overflow, clear, and set-wins against a simultaneous accept.
    req = 8'h08; cyc();
    req = 8'h00; cyc();
    chk_out("s4_present", 1'b1, 8'h08, 3'd3);
    req = 8'h08; cyc();
    chk("s4_ovf", {24'd0, ovf}, 32'h08);
    req = 8'h00; ovf_clr = 1'b1; cyc();
    chk("s4_ovf_clr", {24'd0, ovf}, 32'h00);
    ovf_clr = 1'b0; req = 8'h08; irq_ready = 1'b1; cyc();
    chk("s4_setwins_pending", {24'd0, pending}, 32'h08);
    chk("s4_setwins_ovf", {24'd0, ovf}, 32'h00);
    chk("s4_setwins_valid", {31'd0, irq_valid}, 32'd0);
    req = 8'h00; irq_ready = 1'b0; cyc();
    chk_out("s4_represent", 1'b1, 8'h08, 3'd3);
    // Overflow event beats a coincident ovf_clr.
    req = 8'h08; ovf_clr = 1'b1; cyc();
    chk("s4_ovf_beats_clr", {24'd0, ovf}, 32'h08);
    req = 8'h00; ovf_clr = 1'b0; irq_ready = 1'b1; cyc();
    irq_ready = 1'b0; ovf_clr = 1'b1; cyc();
    ovf_clr = 1'b0;
    chk("s4_pending_empty", {24'd0, pending}, 32'h00);

    // Line held high through reset release is not an edge.
    req = 8'hFF; rst = 1'b1; cyc();
    rst = 1'b0; cyc();
    cyc();
    chk("s5_pending", {24'd0, pending}, 32'h00);
    chk("s5_valid", {31'd0, irq_valid}, 32'd0);
    req = 8'h00; cyc();
    req = 8'h01; cyc();
    req = 8'h00; cyc();
    chk_out("s5_bit0", 1'b1, 8'h01, 3'd0);

    // Asynchronous reset mid-hold.
    req = 8'h06; cyc();
    req = 8'h00; mask_wr = 1'b1; mask_din = 8'h0F; cyc();
    mask_wr = 1'b0;
    chk("s6_pending_before", {24'd0, pending}, 32'h07);
    chk("s6_mask_before", {24'd0, mask}, 32'h0F);
    chk_out("s6_hold", 1'b1, 8'h01, 3'd0);
    #2 rst = 1'b1;
    #1;
    chk_out("s6_async", 1'b0, 8'h00, 3'd0);
    chk("s6_pending", {24'd0, pending}, 32'h00);
    chk("s6_mask", {24'd0, mask}, 32'hFF);
    chk("s6_ovf", {24'd0, ovf}, 32'h00);
    cyc();
    rst = 1'b0;
    cyc();

    // Mixed traffic against the model.
    for (int n = 0; n < 80; n++) begin
      req       = 8'($urandom);
      irq_ready = 1'($urandom_range(0, 1));
      mask_wr   = ($urandom_range(0, 7) == 0);
      mask_din  = 8'($urandom);
      ovf_clr   = ($urandom_range(0, 5) == 0);
      cyc();
    end
    req = 8'h00; irq_ready = 1'b1; mask_wr = 1'b0; ovf_clr = 1'b0;
    repeat (12) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_arbiter8.md
IRQ_ARBITER8 -- requirements
Module: irq_arbiter8

Interface
REQ-001 The block SHALL have parameter MASK_RESET, default 8'hFF, giving the value loaded into the mask register on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: level request lines, synchronous to clk; bit 7 has highest priority.
REQ-005 The block SHALL have port mask_wr, input, 1 bit: a write strobe for the mask register.
REQ-006 The block SHALL have port mask_din, input, 8 bits: the mask write data; 1 = line enabled.
REQ-007 The block SHALL have port ovf_clr, input, 1 bit: a pulse that clears all overflow flags.
REQ-008 The block SHALL have port irq_ready, input, 1 bit: the consumer accepts the presented request.
REQ-009 The block SHALL have port irq_valid, output, 1 bit: a presented request is valid.
REQ-010 The block SHALL have port irq_onehot, output, 8 bits: the presented request, one-hot.
REQ-011 The block SHALL have port irq_id, output, 3 bits: the binary index of the irq_onehot bit.
REQ-012 The block SHALL have port pending, output, 8 bits: the pending register.
REQ-013 The block SHALL have port mask, output, 8 bits: the mask register.
REQ-014 The block SHALL have port ovf, output, 8 bits: sticky per-line overflow flags.

Function
REQ-015 The block SHALL register req into req_q every cycle and define rise = req & ~req_q.
REQ-016 A rise bit SHALL set the matching pending bit at the same edge, regardless of mask.
REQ-017 An accept (irq_valid & irq_ready at an edge) SHALL clear the pending bit selected by irq_onehot at that edge.
REQ-018 When a rise and a clear hit the same bit at the same edge, set SHALL win; that bit's pending stays 1 and ovf is not set.
REQ-019 A rise on a bit whose pending is 1 and is not being cleared at that edge SHALL set that ovf bit; ovf bits hold until ovf_clr.
REQ-020 When ovf_clr and an overflow event coincide on a bit, the overflow event SHALL win; that ovf bit is 1 afterwards.
REQ-021 mask_wr SHALL load mask_din into mask at the edge; the mask affects selection only, never pending or ovf.
REQ-022 The enabled vector SHALL be pending & mask, computed from registered values.
REQ-023 The output register SHALL have two states, IDLE (irq_valid=0) and HOLD (irq_valid=1).
REQ-024 IDLE->HOLD: at an edge where enabled != 0, the block SHALL load irq_onehot with the highest set bit of enabled, irq_id with its index, and set irq_valid=1.
REQ-025 IDLE->IDLE: at an edge where enabled == 0, irq_onehot and irq_id SHALL be 0.
REQ-026 HOLD->HOLD: while irq_ready=0, irq_onehot and irq_id SHALL stay stable, even if a higher-priority bit arrives, mask changes, or the presented line is masked.
REQ-027 HOLD->IDLE: on accept, irq_valid, irq_onehot and irq_id SHALL go to 0, a mandatory one-cycle bubble; the next selection occurs at the following edge.
REQ-028 Latency from req first sampled high at edge E0 (pending set at E0) to irq_valid=1 SHALL be one edge (E1), provided the block is IDLE at E1 and the line is enabled.
REQ-029 irq_ready while irq_valid=0 SHALL have no effect.
REQ-030 irq_onehot SHALL always be zero or one-hot, and irq_id SHALL be 0 whenever irq_valid=0.

Reset
REQ-031 On rst=1, the block SHALL immediately, without waiting for clk, set irq_valid=0, irq_onehot=0, irq_id=0, pending=0, ovf=0, and mask=MASK_RESET.
REQ-032 On rst=1, req_q SHALL reset to 8'hFF, so a line held high through reset release SHALL NOT produce a rise.
REQ-033 Reset asserted mid-HOLD SHALL discard the presented request and all pending state; no accept is implied.

Verification
REQ-034 Scenario: req=8'h00 after reset, then req=8'h24 for 1 cycle -> pending=8'h24; irq_onehot=8'h20, irq_id=5 one edge later. After accept at that edge, a bubble, then irq_onehot=8'h04, irq_id=2.
REQ-035 Scenario: HOLD on bit 2 with irq_ready=0, then a rise on bit 7 -> output stays 8'h04 until accept. After the bubble, 8'h80 is presented.
REQ-036 Scenario: mask_din=8'h7F written, then a rise on bit 7 -> pending[7]=1 and irq_valid stays 0. Writing mask=8'hFF -> irq_onehot=8'h80 at the next edge.
REQ-037 Scenario: bit 3 pending, second rise on bit 3 without accept -> ovf=8'h08. ovf_clr -> ovf=8'h00. A rise coinciding with the accept of bit 3 -> pending[3]=1 and ovf=8'h00.
REQ-038 Scenario: req=8'hFF held through reset release -> pending stays 8'h00 and irq_valid stays 0. Then req drops to 8'h00 and bit 0 rises -> irq_onehot=8'h01.
REQ-039 Scenario: rst pulsed asynchronously mid-HOLD -> all outputs go to reset values before the next clk edge.
